// File: rtl/i2c_req_arbiter_pkg.sv
// Shared types and sizes for the I2C request arbiter slice.
package i2c_arb_pkg;
  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  function automatic logic [1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    onehot_to_idx = 2'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) onehot_to_idx = 2'(i);
    end
  endfunction
endpackage

// File: rtl/i2c_req_arbiter_if.sv
// Requester-side and translator-side signals of the arbiter.
// master = arbiter, slave = requesters plus translator.
interface i2c_req_arbiter_if;
  import i2c_arb_pkg::*;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_rw;
  logic [NUM_REQ*DATA_W-1:0] req_wr_data;
  logic [NUM_REQ-1:0]        req_grant;
  logic [NUM_REQ-1:0]        req_done;
  logic [DATA_W-1:0]         req_rd_data;
  logic                      req_ack_error;

  logic                      up_start;
  logic [ADDR_W-1:0]         up_addr;
  logic                      up_rw;
  logic [DATA_W-1:0]         up_wr_data;
  logic [DATA_W-1:0]         up_rd_data;
  logic                      up_busy;
  logic                      up_done;
  logic                      up_ack_error;

  modport master (
    input  req_valid, req_addr, req_rw, req_wr_data,
    input  up_rd_data, up_busy, up_done, up_ack_error,
    output req_grant, req_done, req_rd_data, req_ack_error,
    output up_start, up_addr, up_rw, up_wr_data
  );

  modport slave (
    output req_valid, req_addr, req_rw, req_wr_data,
    output up_rd_data, up_busy, up_done, up_ack_error,
    input  req_grant, req_done, req_rd_data, req_ack_error,
    input  up_start, up_addr, up_rw, up_wr_data
  );
endinterface

// File: rtl/i2c_rr_pick.sv
// Combinational round-robin pick: first valid requester at or after rr_ptr, wrapping.
module i2c_rr_pick
  import i2c_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [1:0]         rr_ptr,
  output logic [NUM_REQ-1:0] winner
);
  int idx;

  // Walk offsets from farthest to nearest so the nearest valid requester wins last.
  always_comb begin
    winner = '0;
    idx    = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (req_valid[idx]) begin
        winner      = '0;
        winner[idx] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one I2C translator between three requesters.
// Optional WAIT watchdog enabled by defining I2C_ARB_TIMEOUT_EN.
//
// state    | meaning
// ST_IDLE  | no owner; accept a request when translator is not busy
// ST_ISSUE | up_start pulse to translator
// ST_WAIT  | waiting for up_done, collecting NACKs
// ST_RESP  | req_done pulse to owner, advance rr pointer
module i2c_req_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic               clk,
  input logic               rst,
  i2c_req_arbiter_if.master bus
);
  import i2c_arb_pkg::*;

  if (NUM_REQ != i2c_arb_pkg::NUM_REQ) begin : g_num_req_check
    $error("i2c_req_arbiter: NUM_REQ is fixed at 3");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
    $error("i2c_req_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  arb_state_t         state;
  logic [1:0]         rr_ptr;
  logic [1:0]         owner;
  logic [1:0]         win_idx;
  logic [NUM_REQ-1:0] winner;
  logic               err_sticky;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  logic [TMO_W-1:0] tmo_cnt;
`endif

  i2c_rr_pick u_pick (
    .req_valid (bus.req_valid),
    .rr_ptr    (rr_ptr),
    .winner    (winner)
  );

  assign win_idx = onehot_to_idx(winner);

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= ST_IDLE;
      rr_ptr            <= 2'd0;
      owner             <= 2'd0;
      err_sticky        <= 1'b0;
      bus.req_grant     <= '0;
      bus.req_done      <= '0;
      bus.req_rd_data   <= '0;
      bus.req_ack_error <= 1'b0;
      bus.up_start      <= 1'b0;
      bus.up_addr       <= '0;
      bus.up_rw         <= 1'b0;
      bus.up_wr_data    <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
      tmo_cnt           <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if ((|bus.req_valid) && !bus.up_busy) begin
            bus.req_grant  <= winner;
            owner          <= win_idx;
            bus.up_addr    <= bus.req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
            bus.up_rw      <= bus.req_rw[win_idx];
            bus.up_wr_data <= bus.req_wr_data[int'(win_idx)*DATA_W +: DATA_W];
            bus.up_start   <= 1'b1;
            err_sticky     <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
            tmo_cnt        <= TMO_W'(TIMEOUT_CYCLES - 1);
`endif
            state          <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          bus.up_start <= 1'b0;
          state        <= ST_WAIT;
        end
        ST_WAIT: begin
          // Translator flags NACK a cycle ahead of up_done, so hold it here.
          err_sticky <= err_sticky | bus.up_ack_error;
          if (bus.up_done) begin
            bus.req_done      <= bus.req_grant;
            bus.req_rd_data   <= bus.up_rd_data;
            bus.req_ack_error <= err_sticky | bus.up_ack_error;
            state             <= ST_RESP;
          end
`ifdef I2C_ARB_TIMEOUT_EN
          else if (tmo_cnt == '0) begin
            bus.req_done      <= bus.req_grant;
            bus.req_rd_data   <= '0;
            bus.req_ack_error <= 1'b1;
            state             <= ST_RESP;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
`endif
        end
        ST_RESP: begin
          bus.req_done  <= '0;
          bus.req_grant <= '0;
          rr_ptr        <= (owner == 2'(NUM_REQ - 1)) ? 2'd0 : owner + 2'd1;
          state         <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed bench for i2c_req_arbiter; the timeout step is built only with I2C_ARB_TIMEOUT_EN.
module tb_i2c_req_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt [3];
  int   s0, s1, s2;

  i2c_req_arbiter_if bus ();

  i2c_req_arbiter #(.NUM_REQ(3), .TIMEOUT_CYCLES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (bus.req_done[i] === 1'b1) done_cnt[i]++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input string tag, input logic [2:0] gnt, input logic [6:0] addr,
                         input logic rw, input logic [7:0] wd, input logic [7:0] rd,
                         input logic nack, input int extra, input int max_wait,
                         input logic [2:0] wait_valid, input logic [2:0] after_valid);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_wait && !seen; i++) begin
      tick();
      seen = (bus.up_start === 1'b1);
    end
    chk({tag, "_start"}, 32'(seen), 32'd1);
    if (!seen) return;
    chk({tag, "_grant"}, 32'(bus.req_grant), 32'(gnt));
    chk({tag, "_addr"}, 32'(bus.up_addr), 32'(addr));
    chk({tag, "_rw"}, 32'(bus.up_rw), 32'(rw));
    if (!rw) chk({tag, "_wdata"}, 32'(bus.up_wr_data), 32'(wd));
    tick();
    chk({tag, "_start_1cyc"}, 32'(bus.up_start), 32'd0);
    bus.req_valid = wait_valid;
    repeat (extra) tick();
    if (nack) begin
      bus.up_ack_error = 1'b1;
      tick();
      bus.up_ack_error = 1'b0;
    end
    bus.up_done    = 1'b1;
    bus.up_rd_data = rd;
    tick();
    bus.up_done    = 1'b0;
    bus.up_rd_data = 8'hEE;
    chk({tag, "_done"}, 32'(bus.req_done), 32'(gnt));
    if (rw) chk({tag, "_rdata"}, 32'(bus.req_rd_data), 32'(rd));
    chk({tag, "_err"}, 32'(bus.req_ack_error), 32'(nack));
    bus.req_valid = after_valid;
    tick();
    chk({tag, "_done_clr"}, 32'(bus.req_done), 32'd0);
    chk({tag, "_grant_clr"}, 32'(bus.req_grant), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, 32'(bus.req_grant), 32'd0);
    chk({tag, "_done"}, 32'(bus.req_done), 32'd0);
    chk({tag, "_rdata"}, 32'(bus.req_rd_data), 32'd0);
    chk({tag, "_err"}, 32'(bus.req_ack_error), 32'd0);
    chk({tag, "_start"}, 32'(bus.up_start), 32'd0);
    chk({tag, "_addr"}, 32'(bus.up_addr), 32'd0);
    chk({tag, "_rw"}, 32'(bus.up_rw), 32'd0);
    chk({tag, "_wdata"}, 32'(bus.up_wr_data), 32'd0);
  endtask

  initial begin
    bus.req_valid    = 3'b000;
    bus.req_addr     = {7'h35, 7'h22, 7'h10};
    bus.req_rw       = 3'b101;
    bus.req_wr_data  = {8'h33, 8'h22, 8'h11};
    bus.up_rd_data   = 8'h00;
    bus.up_busy      = 1'b0;
    bus.up_done      = 1'b0;
    bus.up_ack_error = 1'b0;

    rst = 1'b1;
    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b0;

    // Single read from requester 0; up_start must follow acceptance by one cycle.
    bus.req_valid = 3'b001;
    run_txn("rd1", 3'b001, 7'h10, 1'b1, 8'h00, 8'hA5, 1'b0, 0, 1, 3'b001, 3'b000);

    // All three held from reset: 0, 1, 2, then 0 again.
    rst = 1'b1;
    tick();
    s0 = done_cnt[0]; s1 = done_cnt[1]; s2 = done_cnt[2];
    bus.req_valid = 3'b111;
    tick();
    rst = 1'b0;
    run_txn("rr0", 3'b001, 7'h10, 1'b1, 8'h11, 8'h5A, 1'b0, 0, 3, 3'b111, 3'b111);
    run_txn("rr1", 3'b010, 7'h22, 1'b0, 8'h22, 8'h00, 1'b0, 2, 3, 3'b111, 3'b111);
    run_txn("rr2", 3'b100, 7'h35, 1'b1, 8'h33, 8'hC3, 1'b0, 1, 3, 3'b111, 3'b111);
    run_txn("rr3", 3'b001, 7'h10, 1'b1, 8'h11, 8'h77, 1'b0, 0, 3, 3'b111, 3'b000);
    chk("rr_done0", 32'(done_cnt[0] - s0), 32'd2);
    chk("rr_done1", 32'(done_cnt[1] - s1), 32'd1);
    chk("rr_done2", 32'(done_cnt[2] - s2), 32'd1);

    // Stray translator returns while idle are ignored.
    bus.up_done      = 1'b1;
    bus.up_ack_error = 1'b1;
    tick();
    bus.up_done      = 1'b0;
    bus.up_ack_error = 1'b0;
    tick();
    chk("stray_done", 32'(bus.req_done), 32'd0);
    chk("stray_grant", 32'(bus.req_grant), 32'd0);

    // NACK reported with req_done, then a clean transaction reports no error.
    bus.req_valid = 3'b010;
    run_txn("nack", 3'b010, 7'h22, 1'b0, 8'h22, 8'h00, 1'b1, 1, 3, 3'b010, 3'b010);
    run_txn("post_nack", 3'b010, 7'h22, 1'b0, 8'h22, 8'h00, 1'b0, 0, 3, 3'b010, 3'b000);

    // Translator busy blocks acceptance.
    bus.up_busy   = 1'b1;
    bus.req_valid = 3'b001;
    repeat (3) tick();
    chk("busy_grant", 32'(bus.req_grant), 32'd0);
    chk("busy_start", 32'(bus.up_start), 32'd0);
    bus.up_busy = 1'b0;
    run_txn("busy_rel", 3'b001, 7'h10, 1'b1, 8'h11, 8'h96, 1'b0, 0, 1, 3'b001, 3'b000);

    // Reset during WAIT abandons the transaction and restarts the pointer at 0.
    bus.req_valid = 3'b101;
    s2 = done_cnt[2];
    tick();
    chk("rstw_start", 32'(bus.up_start), 32'd1);
    chk("rstw_grant", 32'(bus.req_grant), 32'b100);
    tick();
    rst = 1'b1;
    tick();
    chk_all_zero("rstw");
    rst = 1'b0;
    run_txn("post_rst", 3'b001, 7'h10, 1'b1, 8'h11, 8'h4B, 1'b0, 0, 3, 3'b101, 3'b000);
    chk("rstw_no_done2", 32'(done_cnt[2] - s2), 32'd0);

    // Owner drops valid in WAIT while requester 2 waits.
    bus.req_valid = 3'b010;
    run_txn("drop", 3'b010, 7'h22, 1'b0, 8'h22, 8'h00, 1'b0, 2, 3, 3'b100, 3'b100);
    run_txn("r2_next", 3'b100, 7'h35, 1'b1, 8'h33, 8'h3E, 1'b0, 0, 3, 3'b100, 3'b000);

`ifdef I2C_ARB_TIMEOUT_EN
    // Watchdog: 16 WAIT cycles without up_done forces an error response.
    bus.req_valid = 3'b001;
    tick();
    chk("tmo_start", 32'(bus.up_start), 32'd1);
    repeat (16) tick();
    chk("tmo_early", 32'(bus.req_done), 32'd0);
    tick();
    chk("tmo_done", 32'(bus.req_done), 32'b001);
    chk("tmo_err", 32'(bus.req_ack_error), 32'd1);
    chk("tmo_rdata", 32'(bus.req_rd_data), 32'd0);
    bus.req_valid = 3'b000;
    tick();
    chk("tmo_done_clr", 32'(bus.req_done), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
